// File: rtl/id_ex_stage_if.sv
// ID-to-EX stage bus: decoded instruction in from ID, selected ALU operands out toward EX.
// master = ID producer / EX consumer side, slave = the id_ex_stage buffer.
interface id_ex_stage_if #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 14,
    parameter int RADDR_W  = 5
);
    logic                id_valid;
    logic                id_ready;
    logic [ALU_OP_W-1:0] id_alu_op;
    logic [XLEN-1:0]     id_pc;
    logic [XLEN-1:0]     id_rj_data;
    logic [XLEN-1:0]     id_rk_data;
    logic [XLEN-1:0]     id_imm;
    logic                id_src1_is_pc;
    logic                id_src2_is_imm;
    logic                id_src2_is_4;
    logic [RADDR_W-1:0]  id_rd;
    logic                id_rf_we;

    logic                ex_valid;
    logic                ex_ready;
    logic [ALU_OP_W-1:0] ex_alu_op;
    logic [XLEN-1:0]     ex_alu_src1;
    logic [XLEN-1:0]     ex_alu_src2;
    logic [XLEN-1:0]     ex_pc;
    logic [RADDR_W-1:0]  ex_rd;
    logic                ex_rf_we;
    logic [1:0]          ex_occupancy;

    modport master (
        output id_valid, id_alu_op, id_pc, id_rj_data, id_rk_data, id_imm,
               id_src1_is_pc, id_src2_is_imm, id_src2_is_4, id_rd, id_rf_we,
               ex_ready,
        input  id_ready, ex_valid, ex_alu_op, ex_alu_src1, ex_alu_src2,
               ex_pc, ex_rd, ex_rf_we, ex_occupancy
    );

    modport slave (
        input  id_valid, id_alu_op, id_pc, id_rj_data, id_rk_data, id_imm,
               id_src1_is_pc, id_src2_is_imm, id_src2_is_4, id_rd, id_rf_we,
               ex_ready,
        output id_ready, ex_valid, ex_alu_op, ex_alu_src1, ex_alu_src2,
               ex_pc, ex_rd, ex_rf_we, ex_occupancy
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID->EX stage: selects ALU operands and holds them in a 2-entry skid buffer, 1-cycle latency.
// Backpressure: id_ready is registered (no path from ex_ready) and drops only while both entries are held.
module id_ex_stage #(
    parameter int XLEN     = 32,
    parameter int ALU_OP_W = 14,
    parameter int RADDR_W  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    id_ex_stage_if.slave    bus
);
    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic [XLEN-1:0]     src1;
        logic [XLEN-1:0]     src2;
        logic [XLEN-1:0]     pc;
        logic [RADDR_W-1:0]  rd;
        logic                rf_we;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    entry_t main_q;
    entry_t skid_q;
    entry_t in_ent;
    logic   id_ready_q;
    logic   ex_valid;
    logic   in_fire;
    logic   out_fire;

    // Operand muxing is done before the register so EX sees ready-to-use operands.
    always_comb begin
        in_ent        = '0;
        in_ent.alu_op = bus.id_alu_op;
        in_ent.pc     = bus.id_pc;
        in_ent.rd     = bus.id_rd;
        in_ent.rf_we  = bus.id_rf_we;
        in_ent.src1   = bus.id_src1_is_pc ? bus.id_pc : bus.id_rj_data;
        if (bus.id_src2_is_imm)
            in_ent.src2 = bus.id_imm;
        else if (bus.id_src2_is_4)
            in_ent.src2 = XLEN'(4);
        else
            in_ent.src2 = bus.id_rk_data;
    end

    assign ex_valid = (state != EMPTY);
    assign in_fire  = bus.id_valid & id_ready_q;
    assign out_fire = ex_valid & bus.ex_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            id_ready_q <= 1'b1;
        end else if (flush) begin
            state      <= EMPTY;
            id_ready_q <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_q <= in_ent;
                        state  <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && !out_fire) begin
                        skid_q     <= in_ent;
                        state      <= FULL;
                        id_ready_q <= 1'b0;
                    end else if (in_fire && out_fire) begin
                        main_q <= in_ent;
                    end else if (out_fire) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    // id_ready is low here, so only the drain side can move.
                    if (out_fire) begin
                        main_q     <= skid_q;
                        state      <= ONE;
                        id_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    id_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.id_ready     = id_ready_q;
    assign bus.ex_valid     = ex_valid;
    assign bus.ex_alu_op    = main_q.alu_op;
    assign bus.ex_alu_src1  = main_q.src1;
    assign bus.ex_alu_src2  = main_q.src2;
    assign bus.ex_pc        = main_q.pc;
    assign bus.ex_rd        = main_q.rd;
    assign bus.ex_rf_we     = main_q.rf_we & ex_valid;
    assign bus.ex_occupancy = state;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed + random bench for id_ex_stage; a negedge monitor checks every EX transfer against a queue.
module tb_id_ex_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [115:0] sb[$];
    logic [115:0] prev_obs;
    logic         stall_prev = 1'b0;

    id_ex_stage_if #(.XLEN(32), .ALU_OP_W(14), .RADDR_W(5)) bus ();

    id_ex_stage #(.XLEN(32), .ALU_OP_W(14), .RADDR_W(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [115:0] model(input logic [13:0] op, input logic [31:0] pc,
                                           input logic [31:0] rj, input logic [31:0] rk,
                                           input logic [31:0] imm, input logic s1pc,
                                           input logic s2imm, input logic s24,
                                           input logic [4:0] rd, input logic we);
        logic [31:0] a;
        logic [31:0] b;
        a = s1pc ? pc : rj;
        b = s2imm ? imm : (s24 ? 32'd4 : rk);
        return {op, a, b, pc, rd, we};
    endfunction

    function automatic logic [115:0] observed();
        return {bus.ex_alu_op, bus.ex_alu_src1, bus.ex_alu_src2, bus.ex_pc, bus.ex_rd, bus.ex_rf_we};
    endfunction

    // Monitor: values seen at a negedge are what the next rising edge will sample.
    always @(negedge clk) begin
        logic [115:0] exp_e;
        if (rst) begin
            sb.delete();
            stall_prev = 1'b0;
        end else begin
            chk("occupancy", 128'(bus.ex_occupancy), 128'(sb.size()));
            if (!bus.ex_valid)
                chk("rf_we_gated", 128'(bus.ex_rf_we), 128'(0));
            if (stall_prev) begin
                chk("stall_valid", 128'(bus.ex_valid), 128'(1));
                chk("stall_hold", 128'(observed()), 128'(prev_obs));
            end
            if (bus.ex_valid && bus.ex_ready) begin
                chk("ex_has_expected", 128'(sb.size() != 0), 128'(1));
                if (sb.size() != 0) begin
                    exp_e = sb.pop_front();
                    chk("ex_entry", 128'(observed()), 128'(exp_e));
                end
            end
            if (flush)
                sb.delete();
            else if (bus.id_valid && bus.id_ready)
                sb.push_back(model(bus.id_alu_op, bus.id_pc, bus.id_rj_data, bus.id_rk_data,
                                   bus.id_imm, bus.id_src1_is_pc, bus.id_src2_is_imm,
                                   bus.id_src2_is_4, bus.id_rd, bus.id_rf_we));
            stall_prev = !flush && bus.ex_valid && !bus.ex_ready;
            prev_obs   = observed();
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input int n, input logic s1, input logic s2i, input logic s24);
        bus.id_valid       = 1'b1;
        bus.id_alu_op      = 14'(1 << (n % 14));
        bus.id_pc          = 32'h1C00_0000 + 32'(n * 4);
        bus.id_rj_data     = 32'(n * 3 + 1);
        bus.id_rk_data     = 32'(n * 5 + 2);
        bus.id_imm         = 32'hFFFF_0000 | 32'(n);
        bus.id_src1_is_pc  = s1;
        bus.id_src2_is_imm = s2i;
        bus.id_src2_is_4   = s24;
        bus.id_rd          = 5'(n);
        bus.id_rf_we       = ~n[1];
    endtask

    logic [2:0]  mux_sel [7];
    logic [31:0] mux_s1  [7];
    logic [31:0] mux_s2  [7];

    initial begin
        mux_sel = '{3'b000, 3'b010, 3'b001, 3'b100, 3'b110, 3'b101, 3'b111};
        mux_s1  = '{32'd5, 32'd5, 32'd5, 32'h1C00_0010, 32'h1C00_0010, 32'h1C00_0010, 32'h1C00_0010};
        mux_s2  = '{32'd7, 32'hFFFF_FFF0, 32'd4, 32'd7, 32'hFFFF_FFF0, 32'd4, 32'hFFFF_FFF0};

        bus.id_valid = 1'b0;
        bus.ex_ready = 1'b0;
        set_instr(0, 1'b0, 1'b0, 1'b0);
        bus.id_valid = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_ex_valid", 128'(bus.ex_valid), 128'(0));
        chk("rst_rf_we", 128'(bus.ex_rf_we), 128'(0));
        chk("rst_occ", 128'(bus.ex_occupancy), 128'(0));
        chk("rst_id_ready", 128'(bus.id_ready), 128'(1));
        chk("rst_data", 128'(observed()), 128'(0));
        rst = 1'b0;

        // Stream of 8 ADDs with EX always ready
        bus.ex_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_instr(i, 1'b0, 1'b0, 1'b0);
            step();
            chk("stream_valid", 128'(bus.ex_valid), 128'(1));
            chk("stream_occ", 128'(bus.ex_occupancy), 128'(1));
            chk("stream_src1", 128'(bus.ex_alu_src1), 128'(32'(i * 3 + 1)));
            chk("stream_pc", 128'(bus.ex_pc), 128'(32'h1C00_0000 + 32'(i * 4)));
        end
        bus.id_valid = 1'b0;
        step();
        chk("stream_drained", 128'(bus.ex_occupancy), 128'(0));

        // Backpressure: three offered while EX stalls
        bus.ex_ready = 1'b0;
        set_instr(10, 1'b0, 1'b0, 1'b0);
        step();
        chk("bp_occ1", 128'(bus.ex_occupancy), 128'(1));
        chk("bp_ready1", 128'(bus.id_ready), 128'(1));
        set_instr(11, 1'b0, 1'b0, 1'b0);
        step();
        chk("bp_occ2", 128'(bus.ex_occupancy), 128'(2));
        chk("bp_ready_low", 128'(bus.id_ready), 128'(0));
        set_instr(12, 1'b0, 1'b0, 1'b0);
        step();
        chk("bp_hold_occ", 128'(bus.ex_occupancy), 128'(2));
        chk("bp_head", 128'(bus.ex_alu_src1), 128'(32'd31));
        bus.ex_ready = 1'b1;
        step();
        chk("bp_drain1_occ", 128'(bus.ex_occupancy), 128'(1));
        chk("bp_drain1_head", 128'(bus.ex_alu_src1), 128'(32'd34));
        step();
        chk("bp_third_head", 128'(bus.ex_alu_src1), 128'(32'd37));
        chk("bp_ready_back", 128'(bus.id_ready), 128'(1));
        bus.id_valid = 1'b0;
        step();
        chk("bp_drained", 128'(bus.ex_occupancy), 128'(0));

        // Operand mux table
        for (int i = 0; i < 7; i++) begin
            set_instr(40 + i, mux_sel[i][2], mux_sel[i][1], mux_sel[i][0]);
            bus.id_pc      = 32'h1C00_0010;
            bus.id_rj_data = 32'd5;
            bus.id_rk_data = 32'd7;
            bus.id_imm     = 32'hFFFF_FFF0;
            step();
            chk("mux_src1", 128'(bus.ex_alu_src1), 128'(mux_s1[i]));
            chk("mux_src2", 128'(bus.ex_alu_src2), 128'(mux_s2[i]));
        end
        bus.id_valid = 1'b0;
        step();

        // Flush while FULL with a concurrent ID offer
        bus.ex_ready = 1'b0;
        set_instr(20, 1'b0, 1'b0, 1'b0);
        step();
        set_instr(21, 1'b0, 1'b0, 1'b0);
        step();
        chk("fl_full", 128'(bus.ex_occupancy), 128'(2));
        set_instr(22, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        step();
        chk("fl_valid", 128'(bus.ex_valid), 128'(0));
        chk("fl_rf_we", 128'(bus.ex_rf_we), 128'(0));
        chk("fl_occ", 128'(bus.ex_occupancy), 128'(0));
        chk("fl_ready", 128'(bus.id_ready), 128'(1));
        flush = 1'b0;
        bus.id_valid = 1'b0;
        bus.ex_ready = 1'b1;
        step();
        step();
        chk("fl_gone", 128'(bus.ex_valid), 128'(0));

        // Reset while FULL with EX ready toggling
        bus.ex_ready = 1'b0;
        set_instr(30, 1'b0, 1'b0, 1'b0);
        step();
        set_instr(31, 1'b0, 1'b0, 1'b0);
        step();
        chk("mr_full", 128'(bus.ex_occupancy), 128'(2));
        rst = 1'b1;
        bus.ex_ready = 1'b1;
        set_instr(32, 1'b0, 1'b0, 1'b0);
        step();
        chk("mr_ex_valid", 128'(bus.ex_valid), 128'(0));
        chk("mr_rf_we", 128'(bus.ex_rf_we), 128'(0));
        chk("mr_occ", 128'(bus.ex_occupancy), 128'(0));
        chk("mr_id_ready", 128'(bus.id_ready), 128'(1));
        chk("mr_data", 128'(observed()), 128'(0));
        rst = 1'b0;
        bus.id_valid = 1'b0;
        bus.ex_ready = 1'b0;
        step();

        // Random valid/ready/flush traffic
        for (int c = 0; c < 10000; c++) begin
            bus.id_valid       = ($urandom_range(3) != 0);
            bus.ex_ready       = ($urandom_range(2) != 0);
            flush              = ($urandom_range(63) == 0);
            bus.id_alu_op      = 14'(1 << $urandom_range(13));
            bus.id_pc          = $urandom;
            bus.id_rj_data     = $urandom;
            bus.id_rk_data     = $urandom;
            bus.id_imm         = $urandom;
            bus.id_src1_is_pc  = $urandom_range(1) != 0;
            bus.id_src2_is_imm = $urandom_range(1) != 0;
            bus.id_src2_is_4   = $urandom_range(1) != 0;
            bus.id_rd          = 5'($urandom_range(31));
            bus.id_rf_we       = $urandom_range(1) != 0;
            step();
        end
        bus.id_valid = 1'b0;
        bus.ex_ready = 1'b1;
        flush = 1'b0;
        repeat (4) step();
        chk("final_drain", 128'(sb.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
